// File: rtl/host_reg_slave_if.sv
// host_reg_slave_if: MAC host register bus (chip select, direction, byte address, data).
interface host_reg_slave_if;
    logic        csb;
    logic        wrb;
    logic [7:0]  ca;
    logic [15:0] cd_in;
    logic [15:0] cd_out;

    modport master (output csb, wrb, ca, cd_in, input cd_out);
    modport slave  (input csb, wrb, ca, cd_in, output cd_out);
endinterface

// File: rtl/host_reg_slave.sv
// host_reg_slave: register-file responder on the MAC host bus. Holds the
// configuration words, drives them flat onto cfg_q, strobes the PROM write
// registers and runs the statistics-counter read handshake.
// Optional feature macro: HOST_ACCESS_CNT_EN adds host write/read access
// counters readable at word addresses 35/36 (cleared by any write to either).
module host_reg_slave #(
    parameter int unsigned NUM_REGS   = 35,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic                     clk_reg,
    input  logic                     reset,
    host_reg_slave_if.slave          bus,
    output logic [NUM_REGS*16-1:0]   cfg_q,
    output logic                     prom_tx_wr_p,
    output logic                     prom_rx_wr_p,
    output logic [6:0]               cpu_rd_addr,
    output logic                     cpu_rd_apply,
    input  logic                     cpu_rd_grant,
    input  logic [31:0]              cpu_rd_dout
);
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 7;
    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

    localparam int unsigned A_PROM_TX = 10;
    localparam int unsigned A_PROM_RX = 17;
    localparam int unsigned A_CNT_IDX = 28;
    localparam int unsigned A_APPLY   = 29;
    localparam int unsigned A_STATUS  = 30;
    localparam int unsigned A_DOUT_LO = 31;
    localparam int unsigned A_DOUT_HI = 32;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t        state;
    logic [DW-1:0] storage [NUM_REGS];
    logic [DW-1:0] img     [NUM_REGS];
    logic [1:0]    status;          // {timeout, done}
    logic [31:0]   cap;
    logic [TW-1:0] timer;
    logic [AW-1:0] waddr;
    logic [IW-1:0] idx;
    logic          wr_acc;
    logic          rd_acc;
    logic          in_range;
    logic          writable;
    logic          apply_hit;
    logic          busy;
    logic [DW-1:0] rd_data;
    logic          unused_c;

    function automatic logic [DW-1:0] rst_val(input int n);
        case (n)
            0:       rst_val = 16'h001E;
            1:       rst_val = 16'h0019;
            4:       rst_val = 16'h000C;
            5:       rst_val = 16'h0001;
            6:       rst_val = 16'h0002;
            19:      rst_val = 16'h0040;
            20:      rst_val = 16'h03E8;
            22:      rst_val = 16'h001A;
            23:      rst_val = 16'h0010;
            24:      rst_val = 16'h0001;
            25:      rst_val = 16'h000C;
            26:      rst_val = 16'h05EE;
            27:      rst_val = 16'h0040;
            34:      rst_val = 16'h0004;
            default: rst_val = '0;
        endcase
    endfunction

    // Bus access decode; ca[0] is a byte-lane bit with no meaning here.
    always_comb begin
        waddr     = bus.ca[7:1];
        idx       = IW'(waddr);
        wr_acc    = !bus.csb && !bus.wrb;
        rd_acc    = !bus.csb && bus.wrb;
        in_range  = 32'(waddr) < NUM_REGS;
        writable  = in_range && !(32'(waddr) inside {A_PROM_TX, A_PROM_RX, A_APPLY,
                                                      A_STATUS, A_DOUT_LO, A_DOUT_HI});
        apply_hit = wr_acc && (32'(waddr) == A_APPLY) && bus.cd_in[0];
        busy      = (state == ST_WAIT);
        unused_c  = bus.ca[0];
    end

    // Register image: plain storage overlaid with the live handshake words.
    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) img[i] = storage[i];
        img[IW'(A_APPLY)]   = {15'b0, busy};
        img[IW'(A_STATUS)]  = {14'b0, status};
        img[IW'(A_DOUT_LO)] = cap[15:0];
        img[IW'(A_DOUT_HI)] = cap[31:16];
        cfg_q = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) cfg_q[i*DW +: DW] = img[i];
    end

`ifdef HOST_ACCESS_CNT_EN
    localparam int unsigned A_WR_CNT = 35;
    localparam int unsigned A_RD_CNT = 36;

    logic [DW-1:0] wr_cnt;
    logic [DW-1:0] rd_cnt;
    logic [DW-1:0] rd_cnt_inc;
    logic          cnt_hit;

    // Saturating increment; a read of the counters includes itself.
    always_comb begin
        cnt_hit    = (32'(waddr) == A_WR_CNT) || (32'(waddr) == A_RD_CNT);
        rd_cnt_inc = (rd_cnt == '1) ? rd_cnt : rd_cnt + DW'(1);
    end

    // Host access counters; a write to either counter clears both uncounted.
    always_ff @(posedge clk_reg or negedge reset) begin
        if (!reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (wr_acc && cnt_hit) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_acc && (wr_cnt != '1)) wr_cnt <= wr_cnt + DW'(1);
            if (rd_acc) rd_cnt <= rd_cnt_inc;
        end
    end
`endif

    // Read data select; anything undecoded returns zero.
    always_comb begin
        rd_data = '0;
        if (in_range) rd_data = img[idx];
`ifdef HOST_ACCESS_CNT_EN
        else if (32'(waddr) == A_WR_CNT) rd_data = wr_cnt;
        else if (32'(waddr) == A_RD_CNT) rd_data = rd_cnt_inc;
`endif
    end

    // Configuration storage; read-only and self-clearing words never latch.
    always_ff @(posedge clk_reg or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) storage[i] <= rst_val(i);
        end else if (wr_acc && writable) begin
            storage[idx] <= bus.cd_in;
        end
    end

    // Read data register, holds until the next read.
    always_ff @(posedge clk_reg or negedge reset) begin
        if (!reset) bus.cd_out <= '0;
        else if (rd_acc) bus.cd_out <= rd_data;
    end

    // One-cycle PROM write strobes.
    always_ff @(posedge clk_reg or negedge reset) begin
        if (!reset) begin
            prom_tx_wr_p <= 1'b0;
            prom_rx_wr_p <= 1'b0;
        end else begin
            prom_tx_wr_p <= wr_acc && (32'(waddr) == A_PROM_TX) && bus.cd_in[0];
            prom_rx_wr_p <= wr_acc && (32'(waddr) == A_PROM_RX) && bus.cd_in[0];
        end
    end

    // Counter read handshake: apply, then wait for grant or give up on timeout.
    always_ff @(posedge clk_reg or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cpu_rd_apply <= 1'b0;
            cpu_rd_addr  <= '0;
            timer        <= '0;
            status       <= '0;
            cap          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (apply_hit) begin
                        state        <= ST_WAIT;
                        cpu_rd_apply <= 1'b1;
                        cpu_rd_addr  <= storage[IW'(A_CNT_IDX)][6:0];
                        timer        <= '0;
                        status       <= '0;
                    end
                end
                ST_WAIT: begin
                    if (cpu_rd_grant) begin
                        cap          <= cpu_rd_dout;
                        status       <= 2'b01;
                        cpu_rd_apply <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (timer == TW'(RD_TIMEOUT)) begin
                        status       <= 2'b10;
                        cpu_rd_apply <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
